uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that funnels NREQ byte streams into a shared TX FIFO,
// plus the pop side that feeds one byte at a time to a uart_tx serializer.
module uart_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int MAX_PKT = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_almost_full,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              tx_finish,
  output logic              overflow_err,
  output logic              pkt_len_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(MAX_PKT + 1);
  localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

  typedef enum logic {W_IDLE, W_XFER} w_state_t;
  typedef enum logic {R_IDLE, R_WAIT} r_state_t;

  w_state_t        w_state;
  r_state_t        r_state;
  logic [1:0]      rst_sync;
  logic            run_ok;
  logic [IDXW-1:0] last_granted;
  logic [IDXW-1:0] gidx;
  logic [IDXW-1:0] next_idx;
  logic            next_found;
  logic [CNTW-1:0] byte_cnt;
  logic [CNTW-1:0] cnt_next;
  logic [7:0]      sel_byte;
  logic            accept;
  logic            pkt_end;

  // Reset assertion is immediate; release is held off two clocks so both FSMs
  // leave idle on a clean edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run_ok = rst_sync[1];

  always_comb begin
    int cand;
    cand       = 0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_granted) + k) % NREQ;
      if (!next_found && req_valid[cand]) begin
        next_found = 1'b1;
        next_idx   = IDXW'(cand);
      end
    end
  end

  assign req_ready = (w_state == W_XFER && !fifo_almost_full && !fifo_full) ? grant : '0;
  assign sel_byte  = req_data[{gidx, 3'b000} +: 8];
  assign accept    = (w_state == W_XFER) && |(req_valid & req_ready);
  assign cnt_next  = byte_cnt + CNTW'(1);
  assign pkt_end   = req_last[gidx] || (cnt_next == CNTW'(MAX_PKT));

  // A packet that hits MAX_PKT without req_last is cut there; the requester's
  // remaining bytes compete again as a fresh packet.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      w_state      <= W_IDLE;
      grant        <= '0;
      gidx         <= '0;
      last_granted <= IDXW'(NREQ - 1);
      byte_cnt     <= '0;
      fifo_din     <= '0;
      fifo_wr_en   <= 1'b0;
      overflow_err <= 1'b0;
      pkt_len_err  <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (fifo_wr_en && fifo_full) overflow_err <= 1'b1;
      case (w_state)
        W_IDLE: begin
          if (run_ok && next_found) begin
            grant    <= GRANT_ONE << next_idx;
            gidx     <= next_idx;
            byte_cnt <= '0;
            w_state  <= W_XFER;
          end
        end
        W_XFER: begin
          if (accept) begin
            fifo_din   <= sel_byte;
            fifo_wr_en <= 1'b1;
            byte_cnt   <= cnt_next;
            if (pkt_end) begin
              w_state      <= W_IDLE;
              grant        <= '0;
              last_granted <= gidx;
              byte_cnt     <= '0;
              if (!req_last[gidx]) pkt_len_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // The pop is combinational so it lands in the very cycle after tx_finish.
  assign fifo_rd_en = run_ok && (r_state == R_IDLE) && !fifo_empty;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
    end else begin
      case (r_state)
        R_IDLE: if (fifo_rd_en) r_state <= R_WAIT;
        R_WAIT: if (tx_finish)  r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, backpressure,
// packet truncation, read pacing, overflow and mid-packet reset.
module tb_uart_tx_arbiter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx_finish;
  logic        overflow_err;
  logic        pkt_len_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NREQ(3), .MAX_PKT(16)) dut (
    .clk_in           (clk_in),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .grant            (grant),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .tx_finish        (tx_finish),
    .overflow_err     (overflow_err),
    .pkt_len_err      (pkt_len_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [23:0] data,
                               input logic [2:0] last);
    req_valid = valid;
    req_data  = data;
    req_last  = last;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int idx;
    int nwr;
    int grants;
    int pulses;
    logic [2:0] prev_grant;
    logic will;

    rst = 1'b0;
    applyStimulus(3'b000, 24'h0, 3'b000);
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    fifo_empty = 1'b1;
    tx_finish = 1'b0;
    repeat (3) tick();
    $display("[TB] reset state");
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    checkOutput("rst_din", 32'(fifo_din), 32'h0);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    checkOutput("rst_errs", 32'({overflow_err, pkt_len_err}), 32'h0);
    rst = 1'b1;
    repeat (3) tick();

    $display("[TB] three-byte packet from requester 0");
    applyStimulus(3'b001, 24'h0000A1, 3'b000);
    tick();
    checkOutput("p0_grant", 32'(grant), 32'h1);
    checkOutput("p0_ready", 32'(req_ready), 32'h1);
    checkOutput("p0_wr_idle", 32'(fifo_wr_en), 32'h0);
    tick();
    checkOutput("p0_wr1", 32'(fifo_wr_en), 32'h1);
    checkOutput("p0_din1", 32'(fifo_din), 32'hA1);
    applyStimulus(3'b001, 24'h0000A2, 3'b000);
    tick();
    checkOutput("p0_wr2", 32'(fifo_wr_en), 32'h1);
    checkOutput("p0_din2", 32'(fifo_din), 32'hA2);
    applyStimulus(3'b001, 24'h0000A3, 3'b001);
    tick();
    checkOutput("p0_wr3", 32'(fifo_wr_en), 32'h1);
    checkOutput("p0_din3", 32'(fifo_din), 32'hA3);
    checkOutput("p0_grant_end", 32'(grant), 32'h0);
    checkOutput("p0_ready_end", 32'(req_ready), 32'h0);
    applyStimulus(3'b000, 24'h0, 3'b000);
    tick();
    checkOutput("p0_wr_after", 32'(fifo_wr_en), 32'h0);

    $display("[TB] round robin across three requesters");
    doReset();
    applyStimulus(3'b111, 24'h121110, 3'b111);
    tick();
    checkOutput("rr_grant0", 32'(grant), 32'h1);
    tick();
    checkOutput("rr_din0", 32'(fifo_din), 32'h10);
    checkOutput("rr_idle0", 32'(grant), 32'h0);
    tick();
    checkOutput("rr_grant1", 32'(grant), 32'h2);
    tick();
    checkOutput("rr_din1", 32'(fifo_din), 32'h11);
    tick();
    checkOutput("rr_grant2", 32'(grant), 32'h4);
    tick();
    checkOutput("rr_din2", 32'(fifo_din), 32'h12);
    tick();
    checkOutput("rr_grant3", 32'(grant), 32'h1);
    tick();
    checkOutput("rr_din3", 32'(fifo_din), 32'h10);
    applyStimulus(3'b000, 24'h0, 3'b000);
    tick();

    $display("[TB] almost-full backpressure");
    fifo_almost_full = 1'b1;
    applyStimulus(3'b010, 24'h005500, 3'b000);
    tick();
    checkOutput("af_grant", 32'(grant), 32'h2);
    checkOutput("af_ready_blocked", 32'(req_ready), 32'h0);
    tick();
    checkOutput("af_no_wr1", 32'(fifo_wr_en), 32'h0);
    tick();
    checkOutput("af_no_wr2", 32'(fifo_wr_en), 32'h0);
    fifo_almost_full = 1'b0;
    #1;
    checkOutput("af_ready_resume", 32'(req_ready), 32'h2);
    tick();
    checkOutput("af_wr1", 32'(fifo_wr_en), 32'h1);
    checkOutput("af_din1", 32'(fifo_din), 32'h55);
    applyStimulus(3'b010, 24'h006600, 3'b010);
    fifo_almost_full = 1'b1;
    tick();
    checkOutput("af_no_dup", 32'(fifo_wr_en), 32'h0);
    fifo_almost_full = 1'b0;
    tick();
    checkOutput("af_wr2", 32'(fifo_wr_en), 32'h1);
    checkOutput("af_din2", 32'(fifo_din), 32'h66);
    checkOutput("af_grant_end", 32'(grant), 32'h0);
    applyStimulus(3'b000, 24'h0, 3'b000);
    tick();
    checkOutput("af_wr_after", 32'(fifo_wr_en), 32'h0);

    $display("[TB] twenty-byte packet truncated at sixteen");
    checkOutput("len_err_clear", 32'(pkt_len_err), 32'h0);
    idx = 1;
    nwr = 0;
    grants = 0;
    prev_grant = 3'b000;
    for (int c = 0; c < 80 && nwr < 20; c++) begin
      applyStimulus((idx <= 20) ? 3'b010 : 3'b000, {8'h00, 8'(8'h20 + idx), 8'h00},
                    (idx == 20) ? 3'b010 : 3'b000);
      will = req_ready[1] && req_valid[1];
      tick();
      if (will) idx++;
      if (grant == 3'b010 && prev_grant != 3'b010) grants++;
      prev_grant = grant;
      if (fifo_wr_en) begin
        nwr++;
        checkOutput("long_din", 32'(fifo_din), 32'(8'h20 + nwr));
        if (nwr == 15) checkOutput("long_err_before", 32'(pkt_len_err), 32'h0);
        if (nwr == 16) checkOutput("long_err_at16", 32'(pkt_len_err), 32'h1);
      end
    end
    checkOutput("long_count", 32'(nwr), 32'd20);
    checkOutput("long_grants", 32'(grants), 32'd2);
    applyStimulus(3'b000, 24'h0, 3'b000);
    tick();
    checkOutput("long_err_sticky", 32'(pkt_len_err), 32'h1);
    checkOutput("long_grant_idle", 32'(grant), 32'h0);

    $display("[TB] read side pacing");
    checkOutput("rd_none_empty", 32'(fifo_rd_en), 32'h0);
    fifo_empty = 1'b0;
    #1;
    checkOutput("rd_pop1", 32'(fifo_rd_en), 32'h1);
    tick();
    checkOutput("rd_pop1_single", 32'(fifo_rd_en), 32'h0);
    pulses = 0;
    for (int c = 0; c < 99; c++) begin
      tick();
      if (fifo_rd_en) pulses++;
    end
    checkOutput("rd_wait1", 32'(pulses), 32'd0);
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    checkOutput("rd_pop2", 32'(fifo_rd_en), 32'h1);
    tick();
    fifo_empty = 1'b1;
    checkOutput("rd_pop2_single", 32'(fifo_rd_en), 32'h0);
    pulses = 0;
    for (int c = 0; c < 99; c++) begin
      tick();
      if (fifo_rd_en) pulses++;
    end
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    repeat (5) begin
      tick();
      if (fifo_rd_en) pulses++;
    end
    tx_finish = 1'b1;
    tick();
    tx_finish = 1'b0;
    tick();
    if (fifo_rd_en) pulses++;
    checkOutput("rd_none_when_empty", 32'(pulses), 32'd0);

    $display("[TB] overflow then reset mid-packet");
    applyStimulus(3'b001, 24'h000077, 3'b000);
    tick();
    checkOutput("ov_grant", 32'(grant), 32'h1);
    tick();
    checkOutput("ov_wr", 32'(fifo_wr_en), 32'h1);
    fifo_full = 1'b1;
    tick();
    checkOutput("ov_err", 32'(overflow_err), 32'h1);
    checkOutput("ov_no_wr", 32'(fifo_wr_en), 32'h0);
    fifo_full = 1'b0;
    fifo_empty = 1'b0;
    applyStimulus(3'b001, 24'h000088, 3'b000);
    rst = 1'b0;
    #1;
    checkOutput("mr_grant", 32'(grant), 32'h0);
    checkOutput("mr_ready", 32'(req_ready), 32'h0);
    checkOutput("mr_wr_en", 32'(fifo_wr_en), 32'h0);
    checkOutput("mr_din", 32'(fifo_din), 32'h0);
    checkOutput("mr_rd_en", 32'(fifo_rd_en), 32'h0);
    checkOutput("mr_errs", 32'({overflow_err, pkt_len_err}), 32'h0);
    fifo_empty = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("mr_sync1_grant", 32'(grant), 32'h0);
    tick();
    checkOutput("mr_sync2_grant", 32'(grant), 32'h0);
    tick();
    checkOutput("mr_new_grant", 32'(grant), 32'h1);
    checkOutput("mr_new_no_wr", 32'(fifo_wr_en), 32'h0);
    tick();
    checkOutput("mr_new_wr", 32'(fifo_wr_en), 32'h1);
    checkOutput("mr_new_din", 32'(fifo_din), 32'h88);
    checkOutput("mr_errs_after", 32'({overflow_err, pkt_len_err}), 32'h0);
    applyStimulus(3'b001, 24'h000099, 3'b001);
    tick();
    applyStimulus(3'b000, 24'h0, 3'b000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
